// File: rtl/das_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : das_accumulator
// Purpose  : Delay-and-sum beamformer accumulator. Takes a time-multiplexed
//            stream of already-delayed channel samples (one channel per valid
//            beat), applies a programmable signed apodization weight per
//            channel and sums the products over a frame of CHANNELS samples.
//            One beam sample is emitted per complete frame.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   din        : signed delayed sample
//   din_valid  : din qualifier
//   din_first  : marks channel 0 of a frame (qualified by din_valid)
//   w_we       : weight write strobe
//   w_addr     : weight index
//   w_data     : signed weight value
//   dout       : signed beam sum, held between frames
//   dout_valid : one-cycle pulse when dout is updated
//   frame_err  : one-cycle pulse on a framing violation
//   busy       : high while a frame is partially accepted
// ============================================================================
module das_accumulator #(
  parameter  int DATA_WIDTH   = 16,
  parameter  int CHANNELS     = 8,
  parameter  int WEIGHT_WIDTH = 8,
  localparam int CH_BITS      = $clog2(CHANNELS),
  localparam int OUT_WIDTH    = DATA_WIDTH + WEIGHT_WIDTH + CH_BITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [DATA_WIDTH-1:0]   din,
  input  logic                           din_valid,
  input  logic                           din_first,
  input  logic                           w_we,
  input  logic        [CH_BITS-1:0]      w_addr,
  input  logic signed [WEIGHT_WIDTH-1:0] w_data,
  output logic signed [OUT_WIDTH-1:0]    dout,
  output logic                           dout_valid,
  output logic                           frame_err,
  output logic                           busy
);

  localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                         state;
  logic        [CH_BITS-1:0]      ch_cnt;
  logic signed [WEIGHT_WIDTH-1:0] weight [CHANNELS];

  // --------------------------------------------------------------------------
  // Sample acceptance. A din_first beat always starts a new frame at channel
  // 0 (in ACCUM this also abandons the partial frame); a plain beat is only
  // taken while a frame is open.
  // --------------------------------------------------------------------------
  logic                          start;
  logic                          cont;
  logic                          accept;
  logic        [CH_BITS-1:0]     ch_sel;
  logic                          last_ch;
  logic signed [PROD_WIDTH-1:0]  prod_next;

  assign start     = din_valid & din_first;
  assign cont      = din_valid & ~din_first & (state == ACCUM);
  assign accept    = start | cont;
  assign ch_sel    = start ? '0 : ch_cnt;
  assign last_ch   = (ch_sel == CH_BITS'(CHANNELS - 1));
  // Weight is read before the edge, so a same-edge write is seen only by
  // later samples.
  assign prod_next = din * weight[ch_sel];

  // --------------------------------------------------------------------------
  // Weight register file, reset to unity gain.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_weight
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          weight[i] <= WEIGHT_WIDTH'(1);
        end else if (w_we && (w_addr == CH_BITS'(i))) begin
          weight[i] <= w_data;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Framing FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ch_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      // Violation: orphan sample while idle, or restart inside a frame.
      frame_err <= din_valid & (din_first ? (state == ACCUM) : (state == IDLE));
      if (accept) begin
        if (last_ch) begin
          state  <= IDLE;
          ch_cnt <= '0;
        end else begin
          state  <= ACCUM;
          ch_cnt <= ch_sel + CH_BITS'(1);
        end
      end
    end
  end

  assign busy = (state == ACCUM);

  // --------------------------------------------------------------------------
  // Stage 1: weighted product
  // --------------------------------------------------------------------------
  logic signed [PROD_WIDTH-1:0] prod;
  logic                         p_valid;
  logic                         p_first;
  logic                         p_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod    <= '0;
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
    end else begin
      p_valid <= accept;
      p_first <= accept & (ch_sel == '0);
      p_last  <= accept & last_ch;
      if (accept) begin
        prod <= prod_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: accumulate. Channel 0 overwrites acc, which is also how an
  // abandoned partial frame gets flushed.
  // --------------------------------------------------------------------------
  logic signed [OUT_WIDTH-1:0] prod_ext;
  logic signed [OUT_WIDTH-1:0] acc;
  logic                        a_last;

  assign prod_ext = {{CH_BITS{prod[PROD_WIDTH-1]}}, prod};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      a_last <= 1'b0;
    end else begin
      a_last <= p_valid & p_last;
      if (p_valid) begin
        acc <= p_first ? prod_ext : acc + prod_ext;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register: captures the completed frame sum.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= a_last;
      if (a_last) begin
        dout <= acc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_das_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_das_accumulator
// Purpose  : Self-checking bench for das_accumulator. Expected frame sums and
//            their arrival cycle are queued as stimulus is driven and matched
//            against each dout_valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_das_accumulator;

  localparam int DW = 16;
  localparam int CH = 8;
  localparam int WW = 8;
  localparam int CB = 3;
  localparam int OW = DW + WW + CB;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic                 din_valid = 1'b0;
  logic                 din_first = 1'b0;
  logic                 w_we = 1'b0;
  logic        [CB-1:0] w_addr = '0;
  logic signed [WW-1:0] w_data = '0;
  logic signed [OW-1:0] dout;
  logic                 dout_valid;
  logic                 frame_err;
  logic                 busy;

  das_accumulator #(
    .DATA_WIDTH   (DW),
    .CHANNELS     (CH),
    .WEIGHT_WIDTH (WW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_first  (din_first),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint val;
    longint cyc;
  } exp_t;

  exp_t   sb_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  int     ferr_cnt = 0;
  int     wm [CH];
  int     fd [CH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: every dout_valid must match the oldest queued frame.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_err) ferr_cnt++;
      if (dout_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_dout_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("dout", longint'(dout), e.val);
          check("latency", longint'(cyc), e.cyc);
        end
      end
    end
  end

  task automatic send(input int d, input bit first);
    @(posedge clk); #1;
    din       = d[DW-1:0];
    din_valid = 1'b1;
    din_first = first;
    w_we      = 1'b0;
  endtask

  task automatic send_w(input int d, input bit first, input int a, input int v);
    @(posedge clk); #1;
    din       = d[DW-1:0];
    din_valid = 1'b1;
    din_first = first;
    w_we      = 1'b1;
    w_addr    = a[CB-1:0];
    w_data    = v[WW-1:0];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      din_valid = 1'b0;
      din_first = 1'b0;
      w_we      = 1'b0;
    end
  endtask

  task automatic wr(input int a, input int v);
    @(posedge clk); #1;
    din_valid = 1'b0;
    din_first = 1'b0;
    w_we      = 1'b1;
    w_addr    = a[CB-1:0];
    w_data    = v[WW-1:0];
    wm[a]     = v;
  endtask

  // Full frame from fd[], optional idle gap between channels.
  task automatic frame(input int gap);
    longint sum = 0;
    for (int i = 0; i < CH; i++) begin
      send(fd[i], i == 0);
      if (i > 0) check("busy_in_frame", busy, 1);
      sum += longint'(fd[i]) * longint'(wm[i]);
      if (i == CH - 1) begin
        exp_t e;
        e.val = sum;
        e.cyc = cyc + 3;
        sb_q.push_back(e);
      end else if (gap > 0) begin
        idle(gap);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    idle(1);
    while (sb_q.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    check("drain_queue_empty", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < CH; i++) wm[i] = 1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    idle(1);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);

    // Default unity weights
    for (int i = 0; i < CH; i++) fd[i] = 200;
    frame(0);
    idle(1);
    check("busy_after_last", busy, 0);
    drain();
    idle(5);
    check("dout_hold", dout, 1600);

    // Mixed-sign weights
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    wr(4, -1); wr(5, -2); wr(6, -3); wr(7, -4);
    for (int i = 0; i < CH; i++) fd[i] = 100;
    frame(0);
    fd = '{10, 0, 0, 0, 0, 0, 0, -20};
    frame(0);
    drain();

    // Full-scale corners, back-to-back frames
    for (int i = 0; i < CH; i++) wr(i, -128);
    for (int i = 0; i < CH; i++) fd[i] = -32768;
    frame(0);
    for (int i = 0; i < CH; i++) wr(i, 127);
    frame(0);
    frame(0);
    drain();

    // Same-edge weight write: ch0 sample uses old weight 1
    for (int i = 0; i < CH; i++) wr(i, 1);
    send_w(10, 1, 0, 5);
    for (int i = 1; i < CH; i++) begin
      send(10, 0);
      if (i == CH - 1) begin
        exp_t e;
        e.val = 80;
        e.cyc = cyc + 3;
        sb_q.push_back(e);
      end
    end
    wm[0] = 5;
    for (int i = 0; i < CH; i++) fd[i] = 10;
    frame(0);
    drain();
    wr(0, 1);
    idle(1);

    // Restart inside a frame
    ferr_cnt = 0;
    send(7, 1); send(7, 0); send(7, 0);
    for (int i = 0; i < CH; i++) fd[i] = 5;
    frame(0);
    drain();
    check("restart_frame_err", ferr_cnt, 1);

    // din_first without valid ignored, then stray sample while idle
    ferr_cnt = 0;
    @(posedge clk); #1;
    din_valid = 1'b0;
    din_first = 1'b1;
    idle(1);
    check("ignored_first_busy", busy, 0);
    send(9, 0);
    idle(2);
    check("stray_frame_err", ferr_cnt, 1);
    check("stray_busy", busy, 0);
    fd = '{1, 2, 3, 4, 5, 6, 7, 8};
    frame(2);
    drain();
    check("gap_frame_err", ferr_cnt, 1);

    // Asynchronous reset mid-frame restores unity weights
    for (int i = 0; i < CH; i++) wr(i, 3);
    send(200, 1); send(200, 0); send(200, 0); send(200, 0);
    #2;
    reset     = 1'b0;
    din_valid = 1'b0;
    din_first = 1'b0;
    #1;
    check("async_rst_dout", dout, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_dout_valid", dout_valid, 0);
    for (int i = 0; i < CH; i++) wm[i] = 1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    idle(4);
    for (int i = 0; i < CH; i++) fd[i] = 200;
    frame(0);
    drain();
    idle(3);
    check("post_reset_dout", dout, 1600);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
